// File: rtl/instr_encoder_if.sv
// Bundles the instruction-encoder request, response and status signals.
// Latency: none (wires only).
// Backpressure: carried by in_ready / out_ready.
// master: request producer and word consumer. slave: the encoder.
// Fields: clr flush, in_* request with kind and operand fields,
// out_* encoded word with word index, illegal_cnt/err/wrap status.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        illegal_cnt;
  logic              err;
  logic              wrap;

  modport master (
    output clr, in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, illegal_cnt, err, wrap
  );

  modport slave (
    input  clr, in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr, illegal_cnt, err, wrap
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes one MIPS-style instruction request into a 32-bit word tagged with a word index.
// Latency: 1 cycle from acceptance to out_valid; illegal kinds produce no word.
// Backpressure: single output register; in_ready = (!out_valid | out_ready) & !clr.
// Ports: clk, rst_n (async active-low); bus (instr_encoder_if.slave) carries
// clr, the in_* request, the out_* word/address and illegal_cnt/err/wrap status.
// Macro ENC_JAL_EN: when defined kind 10 encodes jal, otherwise kind 10 is illegal.
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);

  // Instruction kinds as presented on in_kind
  localparam logic [3:0] K_R    = 4'd0;
  localparam logic [3:0] K_ADDI = 4'd1;
  localparam logic [3:0] K_ANDI = 4'd2;
  localparam logic [3:0] K_ORI  = 4'd3;
  localparam logic [3:0] K_SLTI = 4'd4;
  localparam logic [3:0] K_LW   = 4'd5;
  localparam logic [3:0] K_SW   = 4'd6;
  localparam logic [3:0] K_BEQ  = 4'd7;
  localparam logic [3:0] K_BNE  = 4'd8;
  localparam logic [3:0] K_J    = 4'd9;
  localparam logic [3:0] K_JAL  = 4'd10;

  logic              ready_en_q;   // low in reset, high from first edge after release
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        ill_cnt_q;
  logic              err_q;
  logic              wrap_q;

  logic              kind_legal;
  logic [5:0]        opcode;
  logic [31:0]       enc_word;
  logic              accept;
  logic              accept_legal;
  logic              accept_illegal;
  logic              drain;

  // Opcode lookup and legality
  always_comb begin
    kind_legal = 1'b1;
    opcode     = 6'b000000;
    case (bus.in_kind)
      K_R:    opcode = 6'b000000;
      K_ADDI: opcode = 6'b001000;
      K_ANDI: opcode = 6'b001100;
      K_ORI:  opcode = 6'b001101;
      K_SLTI: opcode = 6'b001010;
      K_LW:   opcode = 6'b100011;
      K_SW:   opcode = 6'b101011;
      K_BEQ:  opcode = 6'b000100;
      K_BNE:  opcode = 6'b000101;
      K_J:    opcode = 6'b000010;
`ifdef ENC_JAL_EN
      K_JAL:  opcode = 6'b000011;
`else
      K_JAL:  kind_legal = 1'b0;
`endif
      default: kind_legal = 1'b0;
    endcase
  end

  // Field packing: R-format, immediate format (kinds 1-8), jump format (kinds 9-10)
  always_comb begin
    enc_word = 32'h0;
    if (bus.in_kind == K_R) begin
      enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
    end else if (bus.in_kind <= K_BNE) begin
      enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm};
    end else begin
      enc_word = {opcode, bus.in_target};
    end
  end

  // clr blocks acceptance so a flush can never be overtaken by a new word
  assign bus.in_ready    = ready_en_q & (~out_valid_q | bus.out_ready) & ~bus.clr;
  assign accept          = bus.in_valid & bus.in_ready;
  assign accept_legal    = accept & kind_legal;
  assign accept_illegal  = accept & ~kind_legal;
  assign drain           = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // Output word register; an illegal acceptance leaves the held word alone,
  // so if that word drains in the same cycle out_valid simply falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
    end else if (bus.clr) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
    end else if (accept_legal) begin
      out_valid_q <= 1'b1;
      out_instr_q <= enc_word;
    end else if (drain) begin
      out_valid_q <= 1'b0;
    end
  end

  // Word index advances on every output handshake and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else if (bus.clr) begin
      addr_q <= '0;
      wrap_q <= 1'b0;
    end else if (drain) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (&addr_q) wrap_q <= 1'b1;
    end
  end

  // Illegal-request accounting, saturating at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_q <= 8'h00;
      err_q     <= 1'b0;
    end else if (bus.clr) begin
      ill_cnt_q <= 8'h00;
      err_q     <= 1'b0;
    end else if (accept_illegal) begin
      err_q <= 1'b1;
      if (ill_cnt_q != 8'hFF) ill_cnt_q <= ill_cnt_q + 8'd1;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.out_addr    = addr_q;
  assign bus.illegal_cnt = ill_cnt_q;
  assign bus.err         = err_q;
  assign bus.wrap        = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a narrow address counter so wrap is exercised.
// Expected words come from a field-level model; a monitor pops them on each handshake.
// Status outputs are compared every cycle against counts kept by the bench.
module tb_instr_encoder;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;
  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          m_ill = 0;
  int          m_drained = 0;
  bit          mon_en = 0;
  int          rdy_mode = 1;   // 0 hold low, 1 hold high, 2 random
  bit          prev_stall = 0;
  logic [31:0] prev_instr;
  logic [31:0] prev_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: returns {legal, word}
  function automatic logic [32:0] model(input logic [3:0] k, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    logic [5:0] op;
    bit ok;
    ok = 1;
    op = 6'b000000;
    case (k)
      4'd0:  op = 6'b000000;
      4'd1:  op = 6'b001000;
      4'd2:  op = 6'b001100;
      4'd3:  op = 6'b001101;
      4'd4:  op = 6'b001010;
      4'd5:  op = 6'b100011;
      4'd6:  op = 6'b101011;
      4'd7:  op = 6'b000100;
      4'd8:  op = 6'b000101;
      4'd9:  op = 6'b000010;
      4'd10: begin
        op = 6'b000011;
`ifndef ENC_JAL_EN
        ok = 0;
`endif
      end
      default: ok = 0;
    endcase
    if (!ok) return 33'h0;
    if (k == 4'd0) return {1'b1, op, rs, rt, rd, sh, fn};
    if (k <= 4'd8) return {1'b1, op, rs, rt, imm};
    return {1'b1, op, tgt};
  endfunction

  // Downstream readiness
  always @(negedge clk) begin
    if (rdy_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
    else               bus.out_ready = (rdy_mode == 1);
  end

  // Monitor: status every cycle, stability while stalled, scoreboard pop on handshake
  always begin
    @(negedge clk);
    #2;
    if (!mon_en || !rst_n) begin
      prev_stall = 0;
    end else begin
      chk("illegal_cnt", 32'(bus.illegal_cnt), 32'(m_ill));
      chk("err", 32'(bus.err), 32'(m_ill != 0));
      chk("wrap", 32'(bus.wrap), 32'(m_drained >= DEPTH));
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_instr", bus.out_instr, prev_instr);
        chk("stall_addr", 32'(bus.out_addr), prev_addr);
      end
      if (bus.out_valid) chk("out_addr", 32'(bus.out_addr), 32'(m_drained % DEPTH));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_word: got 0x%08h expected no word", bus.out_instr);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checks--;
          chk("sb_instr", bus.out_instr, e);
        end
        m_drained++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instr;
      prev_addr  = 32'(bus.out_addr);
    end
  end

  // Drive one request starting at a negedge; returns just after the following
  // negedge (plus 1) with the latency check done for legal kinds.
  task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tgt, output logic [31:0] got);
    logic [32:0] m;
    logic rdy;
    bit done;
    m = model(k, rs, rt, rd, sh, fn, imm, tgt);
    bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_funct = fn; bus.in_imm = imm; bus.in_target = tgt;
    bus.in_valid = 1'b1;
    done = 0;
    got = 32'h0;
    for (int t = 0; t < 100 && !done; t++) begin
      #1 rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        if (m[32]) exp_q.push_back(m[31:0]);
        else m_ill = (m_ill < 255) ? m_ill + 1 : 255;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected acceptance");
    end else if (m[32]) begin
      #1;
      chk("lat_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_instr", bus.out_instr, m[31:0]);
      got = bus.out_instr;
    end
  endtask

  task automatic send_rand();
    logic [31:0] g;
    send(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), g);
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_kind = 4'd0;
    bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_rd = 5'd0; bus.in_shamt = 5'd0;
    bus.in_funct = 6'd0; bus.in_imm = 16'd0; bus.in_target = 26'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    mon_en = 1;
    @(negedge clk);

    // addi then R after one drained word
    send(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, got);
    chk("addi_word", got, 32'h20220005);
    chk("addi_addr", 32'(bus.out_addr), 32'd0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, got);
    chk("r_word", got, 32'h00221820);
    chk("r_addr", 32'(bus.out_addr), 32'd1);

    // back-to-back under a stalled consumer
    rdy_mode = 0;
    send(4'd3, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, got);
    fork
      begin
        repeat (2) @(negedge clk);
        #1 chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        rdy_mode = 1;
      end
      send(4'd2, 5'd6, 5'd7, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0, got);
    join
    chk("second_addr", 32'(bus.out_addr), 32'd3);

    // illegal kind, then lw at the unchanged (wrapped) index
    send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, got);
    send(4'd5, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, got);
    chk("lw_word", got, 32'h8C080004);
    chk("lw_addr", 32'(bus.out_addr), 32'd0);
    chk("lw_ill_cnt", 32'(bus.illegal_cnt), 32'd1);
    chk("lw_err", 32'(bus.err), 32'd1);
    chk("lw_wrap", 32'(bus.wrap), 32'd1);

    // kind 10
    send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000040, got);
`ifdef ENC_JAL_EN
    chk("jal_word", got, 32'h0C000040);
`else
    #1;
    chk("jal_dropped_valid", 32'(bus.out_valid), 32'd0);
    chk("jal_ill_cnt", 32'(bus.illegal_cnt), 32'd2);
`endif

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) send_rand();

    // drive illegal_cnt into saturation
    rdy_mode = 1;
    for (int i = 0; i < 260; i++) begin
      send(4'd11 + 4'($urandom_range(0, 4)), 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, got);
    end
    chk("ill_saturated", 32'(bus.illegal_cnt), 32'd255);

    // clr against a held word with a simultaneous request
    rdy_mode = 0;
    send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3ABCDEF, got);
    @(negedge clk);
    mon_en = 0;
    bus.clr = 1'b1;
    bus.in_kind = 4'd1;
    bus.in_valid = 1'b1;
    #1 chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.clr = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_addr", 32'(bus.out_addr), 32'd0);
    chk("clr_ill_cnt", 32'(bus.illegal_cnt), 32'd0);
    chk("clr_err", 32'(bus.err), 32'd0);
    chk("clr_wrap", 32'(bus.wrap), 32'd0);
    exp_q.delete();
    m_ill = 0;
    m_drained = 0;
    mon_en = 1;
    @(negedge clk);

    // a little traffic to set status again, then asynchronous reset mid-cycle
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) send_rand();
    rdy_mode = 0;
    send(4'd4, 5'd3, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, got);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_instr", bus.out_instr, 32'd0);
    chk("arst_out_addr", 32'(bus.out_addr), 32'd0);
    chk("arst_ill_cnt", 32'(bus.illegal_cnt), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_wrap", 32'(bus.wrap), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    m_ill = 0;
    m_drained = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1 chk("rel_in_ready_after_edge", 32'(bus.in_ready), 32'd1);
    mon_en = 1;
    rdy_mode = 1;
    @(negedge clk);
    send(4'd7, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, got);
    chk("post_arst_addr", 32'(bus.out_addr), 32'd0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, width of the word-index output address.
REQ-002 SHALL provide port clk  input  1  the single clock; all state on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port clr  input  1  synchronous flush of output register and address counter.
REQ-005 SHALL provide port in_valid  input  1  request to encode one instruction.
REQ-006 SHALL provide port in_ready  output  1  encoder can accept a request this cycle.
REQ-007 SHALL provide port in_kind  input  4  0 R-format, 1 addi, 2 andi, 3 ori, 4 slti, 5 lw, 6 sw, 7 beq, 8 bne, 9 j, 10 jal, 11-15 illegal.
REQ-008 SHALL provide ports in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-009 SHALL provide ports in_funct  input  6; in_imm  input  16; in_target  input  26  remaining fields.
REQ-010 SHALL provide port out_valid  output  1  out_instr and out_addr hold a valid word.
REQ-011 SHALL provide port out_ready  input  1  downstream (instruction-memory loader) accepts the word.
REQ-012 SHALL provide ports out_instr  output  32, and out_addr  output  ADDR_W  word index for out_instr.
REQ-013 SHALL provide ports illegal_cnt  output  8; err  output  1; wrap  output  1  status.

Function
REQ-014 Opcodes SHALL be: R 000000, addi 001000, andi 001100, ori 001101, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
REQ-015 R-format SHALL encode {op,rs,rt,rd,shamt,funct}; kinds 1-8 SHALL encode {op,rs,rt,imm}; kinds 9-10 SHALL encode {op,target}.
REQ-016 Request SHALL be accepted on a cycle with in_valid and in_ready high; in_ready SHALL equal (!out_valid | out_ready) & !clr.
REQ-017 Legal accepted request SHALL appear on out_instr with out_valid high exactly one cycle after acceptance (latency 1).
REQ-018 out_instr, out_addr, out_valid SHALL hold stable while out_valid & !out_ready.
REQ-019 Output handshake and new acceptance in the same cycle SHALL replace the word with no bubble.
REQ-020 Address counter SHALL start at 0, increment by 1 on each output handshake; out_addr SHALL present current counter.
REQ-021 Counter at 2**ADDR_W-1 SHALL wrap to 0 on handshake and set sticky wrap.
REQ-022 Illegal kind SHALL be accepted and dropped: no out_valid, counter unchanged, illegal_cnt +1 saturating at 255, err set sticky.
REQ-023 Illegal acceptance while a legal word is held SHALL leave that word untouched; if it drains the same cycle, out_valid SHALL fall.
REQ-024 clr SHALL, next edge, drop out_valid, zero counter, illegal_cnt, err, wrap; clr SHALL win over simultaneous acceptance.

Reset
REQ-025 rst_n low SHALL immediately force out_valid 0, out_instr 0, out_addr 0, illegal_cnt 0, err 0, wrap 0, in_ready 0.
REQ-026 After rst_n release in_ready SHALL be 1 from the first clk edge; a word in flight at reset SHALL be lost.

Configuration
REQ-027 Macro ENC_JAL_EN defined: kind 10 SHALL encode jal (opcode 000011).
REQ-028 Macro ENC_JAL_EN undefined: kind 10 SHALL be treated as illegal per REQ-022.

Verification
REQ-029 addi rs=1 rt=2 imm=0x0005 after reset -> next cycle out_valid=1, out_instr=0x20220005, out_addr=0.
REQ-030 R kind rs=1 rt=2 rd=3 shamt=0 funct=0x20 after one drained word -> out_instr=0x00221820, out_addr=1.
REQ-031 out_ready=0, two back-to-back requests -> first word held stable, in_ready=0; out_ready=1 -> second word next cycle, addr+1.
REQ-032 in_kind=15 then lw rs=0 rt=8 imm=4 -> no output for the illegal, illegal_cnt=1, err=1; lw gives 0x8C080004 at unchanged addr.
REQ-033 kind 10 target=0x0000040 -> with ENC_JAL_EN out_instr=0x0C000040; without, no output and illegal_cnt=1.
REQ-034 ADDR_W=2, five drained words -> out_addr 0,1,2,3,0, wrap=1; rst_n pulse while out_valid=1 -> all outputs 0 asynchronously.
